// File: rtl/avalon_mm_byte_host.sv
// Byte-stream to Avalon-MM host bridge.
// Takes write/read packets as bytes, runs one Avalon-MM transaction with a
// cycle budget, and answers with a status byte, followed by 4 data bytes for reads.
module avalon_mm_byte_host #(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] avl_mm_addr,
  output logic                  avl_mm_read,
  output logic                  avl_mm_write,
  output logic [31:0]           avl_mm_writedata,
  output logic [3:0]            avl_mm_byteenable,
  input  logic                  avl_mm_waitrequest,
  input  logic [31:0]           avl_mm_readdata,
  input  logic                  avl_mm_readdatavalid,
  input  logic [1:0]            avl_mm_response
);

  localparam logic [7:0]  OP_WRITE   = 8'h57;
  localparam logic [7:0]  OP_READ    = 8'h52;
  localparam logic [7:0]  ST_OK      = 8'h00;
  localparam logic [7:0]  ST_BAD_OP  = 8'h40;
  localparam logic [7:0]  ST_TIMEOUT = 8'h80;
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    SEND_STATUS,
    SEND_DATA
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        is_read;
  logic [1:0]  byte_cnt;
  logic [15:0] tmo_cnt;
  logic [7:0]  status;
  logic [31:0] rdata;

  logic rx_fire;
  logic tx_fire;
  logic cmd_accept;
  logic timed_out;
  logic counting;

  // rx_ready is gated by rst_n so it stays low while reset is held but is
  // already high at the first edge after release.
  assign rx_ready   = rst_n && (state == IDLE || state == GET_ADDR || state == GET_DATA);
  assign tx_valid   = (state == SEND_STATUS) || (state == SEND_DATA);
  assign rx_fire    = rx_valid && rx_ready;
  assign tx_fire    = tx_valid && tx_ready;
  assign cmd_accept = (avl_mm_read || avl_mm_write) && !avl_mm_waitrequest;
  assign timed_out  = (tmo_cnt == TMO_LAST);
  assign counting   = (state == WR_ISSUE) || (state == RD_ISSUE) || (state == RD_WAIT);

  // Reply byte mux: status first, then captured read data LSB first.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      SEND_STATUS: tx_data = status;
      SEND_DATA:   tx_data = rdata[{byte_cnt, 3'b000} +: 8];
      default:     tx_data = 8'h00;
    endcase
  end

  // Next-state decode; completion is checked before timeout so it wins a tie.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rx_fire) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) next_state = GET_ADDR;
          else                                             next_state = SEND_STATUS;
        end
      end
      GET_ADDR: begin
        if (rx_fire) next_state = is_read ? RD_ISSUE : GET_DATA;
      end
      GET_DATA: begin
        if (rx_fire && byte_cnt == 2'd3) next_state = WR_ISSUE;
      end
      WR_ISSUE: begin
        if (cmd_accept || timed_out) next_state = SEND_STATUS;
      end
      RD_ISSUE: begin
        if (cmd_accept)     next_state = RD_WAIT;
        else if (timed_out) next_state = SEND_STATUS;
      end
      RD_WAIT: begin
        if (avl_mm_readdatavalid || timed_out) next_state = SEND_STATUS;
      end
      SEND_STATUS: begin
        if (tx_fire) next_state = is_read ? SEND_DATA : IDLE;
      end
      SEND_DATA: begin
        if (tx_fire && byte_cnt == 2'd3) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, packet fields, status/data capture and registered Avalon strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      is_read           <= 1'b0;
      byte_cnt          <= 2'd0;
      status            <= 8'h00;
      rdata             <= 32'h0;
      avl_mm_addr       <= '0;
      avl_mm_read       <= 1'b0;
      avl_mm_write      <= 1'b0;
      avl_mm_writedata  <= 32'h0;
      avl_mm_byteenable <= 4'h0;
    end else begin
      state             <= next_state;
      avl_mm_read       <= (next_state == RD_ISSUE);
      avl_mm_write      <= (next_state == WR_ISSUE);
      avl_mm_byteenable <= 4'hF;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            is_read <= (rx_data == OP_READ);
            if (rx_data != OP_WRITE && rx_data != OP_READ) status <= ST_BAD_OP;
          end
        end
        GET_ADDR: begin
          if (rx_fire) begin
            avl_mm_addr <= rx_data[ADDR_WIDTH-1:0];
            byte_cnt    <= 2'd0;
          end
        end
        GET_DATA: begin
          if (rx_fire) begin
            avl_mm_writedata <= {rx_data, avl_mm_writedata[31:8]};
            byte_cnt         <= byte_cnt + 2'd1;
          end
        end
        WR_ISSUE: begin
          if (cmd_accept)     status <= ST_OK;
          else if (timed_out) status <= ST_TIMEOUT;
        end
        RD_ISSUE: begin
          if (!cmd_accept && timed_out) begin
            status <= ST_TIMEOUT;
            rdata  <= 32'h0;
          end
        end
        RD_WAIT: begin
          if (avl_mm_readdatavalid) begin
            status <= {6'b0, avl_mm_response};
            rdata  <= avl_mm_readdata;
          end else if (timed_out) begin
            status <= ST_TIMEOUT;
            rdata  <= 32'h0;
          end
        end
        SEND_STATUS: begin
          if (tx_fire) byte_cnt <= 2'd0;
        end
        SEND_DATA: begin
          if (tx_fire) byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Transaction budget counter: held at zero outside the Avalon phase, so it
  // starts from zero on entry, and saturates at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tmo_cnt <= 16'd0;
    else if (!counting)            tmo_cnt <= 16'd0;
    else if (tmo_cnt != TMO_LAST)  tmo_cnt <= tmo_cnt + 16'd1;
  end

endmodule

// File: tb/tb_avalon_mm_byte_host.sv
// Scoreboard bench for avalon_mm_byte_host: packets are generated with a
// reference model of the byte protocol, an Avalon slave model answers, and a
// negedge monitor compares Avalon commands and reply bytes against queues.
module tb_avalon_mm_byte_host;

  localparam int AW = 4;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] avl_mm_addr;
  logic          avl_mm_read;
  logic          avl_mm_write;
  logic [31:0]   avl_mm_writedata;
  logic [3:0]    avl_mm_byteenable;
  logic          avl_mm_waitrequest = 1'b0;
  logic [31:0]   avl_mm_readdata = 32'h0;
  logic          avl_mm_readdatavalid = 1'b0;
  logic [1:0]    avl_mm_response = 2'b00;

  avalon_mm_byte_host #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .avl_mm_addr(avl_mm_addr), .avl_mm_read(avl_mm_read), .avl_mm_write(avl_mm_write),
    .avl_mm_writedata(avl_mm_writedata), .avl_mm_byteenable(avl_mm_byteenable),
    .avl_mm_waitrequest(avl_mm_waitrequest), .avl_mm_readdata(avl_mm_readdata),
    .avl_mm_readdatavalid(avl_mm_readdatavalid), .avl_mm_response(avl_mm_response)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    int          hold;
    int          lat;
  } cmd_t;

  cmd_t        exp_cmd_q[$];
  logic [7:0]  exp_reply_q[$];
  logic [31:0] model_mem[16];
  logic [31:0] slave_mem[16];
  int          total_checks = 0;
  int          passed_checks = 0;
  int          cyc = 0;
  int          cfg_wait = 0;
  int          cfg_lat = 1;
  logic [1:0]  cfg_resp = 2'b00;
  bit          hold_low = 1'b0;

  function automatic logic [31:0] initWord(input int i);
    return 32'hA5C30000 ^ (32'(i) * 32'h01030507);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic failNow(input string name);
    total_checks++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Cycle counter used for reply latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Reply consumer with random backpressure, forced low on request.
  initial begin
    forever begin
      @(posedge clk); #1;
      tx_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Avalon slave model: configurable waitrequest length, read latency and response.
  initial begin : slave
    bit          in_cmd = 0, prev_acc = 0, prev_wr = 0, rd_pending = 0;
    logic [3:0]  prev_addr = 0, rd_addr = 0;
    logic [31:0] prev_data = 0;
    int          wait_left = 0, rd_delay = 0;
    for (int i = 0; i < 16; i++) slave_mem[i] = initWord(i);
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        in_cmd = 0; prev_acc = 0; rd_pending = 0;
        avl_mm_waitrequest = 1'b0; avl_mm_readdatavalid = 1'b0;
      end else begin
        if (prev_acc) begin
          if (prev_wr) slave_mem[prev_addr] = prev_data;
          else if (cfg_lat > 0) begin
            rd_pending = 1; rd_delay = cfg_lat; rd_addr = prev_addr;
          end
        end
        avl_mm_readdatavalid = 1'b0;
        avl_mm_readdata      = $urandom;
        avl_mm_response      = 2'($urandom_range(0, 3));
        if (rd_pending) begin
          rd_delay--;
          if (rd_delay == 0) begin
            avl_mm_readdatavalid = 1'b1;
            avl_mm_readdata      = slave_mem[rd_addr];
            avl_mm_response      = cfg_resp;
            rd_pending           = 0;
          end
        end else if ((avl_mm_read || avl_mm_write || tx_valid) && $urandom_range(0, 1) == 1) begin
          avl_mm_readdatavalid = 1'b1;
        end
        if (avl_mm_read || avl_mm_write) begin
          if (!in_cmd) begin
            in_cmd = 1; wait_left = cfg_wait;
          end
          avl_mm_waitrequest = (wait_left > 0);
          if (wait_left > 0) wait_left--;
          prev_acc  = !avl_mm_waitrequest;
          prev_wr   = avl_mm_write;
          prev_addr = avl_mm_addr;
          prev_data = avl_mm_writedata;
        end else begin
          in_cmd = 0; prev_acc = 0;
          avl_mm_waitrequest = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: pops expected commands/replies and checks stability under stalls.
  bit          mon_in_run = 0, lat_pending = 0, prev_stall = 0, prev_txv = 0;
  int          run_len = 0, start_cyc = 0;
  cmd_t        cur;
  logic [7:0]  prev_tx = 8'h00;

  always begin
    @(negedge clk);
    if (!rst_n) begin
      mon_in_run = 0; lat_pending = 0; prev_stall = 0; prev_txv = 0;
      exp_cmd_q.delete();
      exp_reply_q.delete();
    end else begin
      if (avl_mm_read || avl_mm_write) begin
        checkOutput("rw_exclusive", 32'(avl_mm_read && avl_mm_write), 32'd0);
        if (!mon_in_run) begin
          if (exp_cmd_q.size() == 0) failNow("unexpected_cmd");
          else begin
            cur = exp_cmd_q.pop_front();
            mon_in_run = 1; run_len = 0; start_cyc = cyc; lat_pending = 1;
            checkOutput("cmd_kind", 32'(avl_mm_write), 32'(cur.is_wr));
            checkOutput("cmd_addr", 32'(avl_mm_addr), 32'(cur.addr));
            checkOutput("cmd_be", 32'(avl_mm_byteenable), 32'hF);
            if (cur.is_wr) checkOutput("cmd_wdata", avl_mm_writedata, cur.data);
          end
        end else begin
          checkOutput("addr_stable", 32'(avl_mm_addr), 32'(cur.addr));
          if (cur.is_wr) checkOutput("wdata_stable", avl_mm_writedata, cur.data);
        end
        if (mon_in_run) run_len++;
      end else if (mon_in_run) begin
        checkOutput("cmd_hold_cycles", 32'(run_len), 32'(cur.hold));
        mon_in_run = 0;
      end
      if (tx_valid && !prev_txv && lat_pending) begin
        checkOutput("reply_latency", 32'(cyc - start_cyc), 32'(cur.lat));
        lat_pending = 0;
      end
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(tx_valid), 32'd1);
        checkOutput("stall_data", 32'(tx_data), 32'(prev_tx));
      end
      if (tx_valid) checkOutput("rx_ready_during_reply", 32'(rx_ready), 32'd0);
      if (tx_valid && tx_ready) begin
        if (exp_reply_q.size() == 0) failNow("unexpected_reply");
        else checkOutput("reply_byte", 32'(tx_data), 32'(exp_reply_q.pop_front()));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_tx    = tx_data;
      prev_txv   = tx_valid;
    end
  end

  // Offers one byte and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) failNow("rx_accept_wait");
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'($urandom);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  // Waits (bounded) until the reply is complete and the host takes bytes again.
  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (!rx_ready && n < 1000) begin
      @(negedge clk); n++;
    end
    if (n >= 1000) failNow("reply_done_wait");
    @(posedge clk); #1;
  endtask

  // Reference model of one packet: predicts the Avalon command and reply bytes.
  task automatic doPacket(input logic [7:0] op, input logic [3:0] a, input logic [31:0] d,
                          input int w, input int lat, input logic [1:0] resp);
    cmd_t        c;
    bit          to;
    logic [7:0]  ab;
    logic [31:0] rd;
    cfg_wait = w; cfg_lat = lat; cfg_resp = resp;
    ab = {4'($urandom_range(0, 15)), a};
    if (op == 8'h57) begin
      to = (w >= T);
      c.is_wr = 1; c.addr = a; c.data = d;
      c.hold = to ? T : w + 1;
      c.lat  = to ? T : w + 1;
      exp_cmd_q.push_back(c);
      exp_reply_q.push_back(to ? 8'h80 : 8'h00);
      if (!to) model_mem[a] = d;
    end else if (op == 8'h52) begin
      to = (w >= T) || (lat == 0) || (w + lat > T - 1);
      c.is_wr = 0; c.addr = a; c.data = 32'h0;
      c.hold = (w >= T) ? T : w + 1;
      c.lat  = to ? T : w + lat + 1;
      exp_cmd_q.push_back(c);
      rd = to ? 32'h0 : model_mem[a];
      exp_reply_q.push_back(to ? 8'h80 : {6'b0, resp});
      for (int k = 0; k < 4; k++) exp_reply_q.push_back(rd[8*k +: 8]);
    end else begin
      exp_reply_q.push_back(8'h40);
    end
    applyStimulus(op);
    if (op == 8'h57 || op == 8'h52) applyStimulus(ab);
    if (op == 8'h57) for (int k = 0; k < 4; k++) applyStimulus(d[8*k +: 8]);
    waitIdle();
  endtask

  // Asserts reset, checks every output is zero at once, then releases.
  task automatic doReset();
    @(posedge clk); #1;
    rst_n = 1'b0; rx_valid = 1'b0;
    #1;
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_read", 32'(avl_mm_read), 32'd0);
    checkOutput("rst_write", 32'(avl_mm_write), 32'd0);
    checkOutput("rst_addr", 32'(avl_mm_addr), 32'd0);
    checkOutput("rst_wdata", avl_mm_writedata, 32'd0);
    checkOutput("rst_be", 32'(avl_mm_byteenable), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rx_ready_after_reset", 32'(rx_ready), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] bad;
    int         r, n;
    for (int i = 0; i < 16; i++) model_mem[i] = initWord(i);
    doReset();

    // Plain write, then a stalled read of a known word.
    doPacket(8'h57, 4'd3, 32'h12345678, 0, 1, 2'b00);
    doPacket(8'h57, 4'd2, 32'hCAFEF00D, 0, 1, 2'b00);
    doPacket(8'h52, 4'd2, 32'h0, 3, 2, 2'b00);
    // Read that never returns data, error response, bad opcode then recovery.
    doPacket(8'h52, 4'd1, 32'h0, 0, 0, 2'b00);
    doPacket(8'h52, 4'd5, 32'h0, 1, 1, 2'b11);
    doPacket(8'hAA, 4'd0, 32'h0, 0, 1, 2'b00);
    doPacket(8'h52, 4'd3, 32'h0, 0, 1, 2'b00);
    // Timeout boundaries: completion on the last budget cycle wins.
    doPacket(8'h57, 4'd7, 32'h0BADBEEF, T - 1, 1, 2'b00);
    doPacket(8'h57, 4'd8, 32'h11112222, T, 1, 2'b00);
    doPacket(8'h52, 4'd7, 32'h0, 2, 5, 2'b01);
    doPacket(8'h52, 4'd8, 32'h0, 3, 5, 2'b00);

    // Hold the reply consumer off for 10 cycles during a read reply.
    hold_low = 1'b1;
    fork
      doPacket(8'h52, 4'd3, 32'h0, 0, 1, 2'b00);
      begin
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 200) begin
          @(negedge clk); n++;
        end
        if (n >= 200) failNow("backpressure_wait");
        repeat (10) @(posedge clk);
        #1;
        hold_low = 1'b0;
      end
    join

    // Reset during a partial packet, then during an outstanding write.
    applyStimulus(8'h57);
    applyStimulus(8'h03);
    applyStimulus(8'h78);
    doReset();
    cfg_wait = 1000;
    begin
      cmd_t c;
      c.is_wr = 1; c.addr = 4'd9; c.data = 32'hDEADBEEF; c.hold = 0; c.lat = 0;
      exp_cmd_q.push_back(c);
    end
    applyStimulus(8'h57);
    applyStimulus(8'h09);
    applyStimulus(8'hEF); applyStimulus(8'hBE); applyStimulus(8'hAD); applyStimulus(8'hDE);
    n = 0;
    @(negedge clk);
    while (!avl_mm_write && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) failNow("write_start_wait");
    doReset();
    repeat (20) @(posedge clk);
    #1;
    doPacket(8'h52, 4'd9, 32'h0, 0, 1, 2'b00);

    // Randomized packet mix.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      do bad = 8'($urandom); while (bad == 8'h57 || bad == 8'h52);
      doPacket(r < 5 ? 8'h57 : (r < 9 ? 8'h52 : bad), 4'($urandom_range(0, 15)), $urandom,
               $urandom_range(0, 3), $urandom_range(1, 4),
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    checkOutput("reply_queue_drained", 32'(exp_reply_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
